regbank_wr_arb: RTL
===================

# regbank_wr_arb

Write-port arbiter and sequencer for the processor's register bank. Each register is a DW-wide group of `ff_dce` cells sharing one enable. The block accepts write requests from NREQ requesters through valid/ready handshakes and grants one per cycle by round-robin. It drives a registered one-hot enable vector and a shared data bus into the bank, so at most one register is written per clock.

## Interface
- NREQ, 4, number of write requesters (2..8)
- NREG, 8, number of registers in the bank (2..32; need not be a power of two)
- DW, 8, register data width
- AW, $clog2(NREG), derived address width (localparam)
- IW, $clog2(NREQ), derived requester-index width (localparam)

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- freeze  in  1  stall; while high, no grants are issued
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed target addresses; requester i is at [i*AW +: AW]
- req_data  in  NREQ*DW  packed write data; requester i is at [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant, combinational; transfer = valid & ready
- reg_en  out  NREG  registered one-hot enable to the bank's `ff_dce` en pins
- reg_d  out  DW  registered write data to the bank's d pins
- grant_id  out  IW  registered index of the requester whose write is on reg_en/reg_d
- grant_vld  out  1  registered; high when the last cycle's grant is being presented
- err_addr  out  1  sticky; set when a granted address is ≥ NREG

## Operation
- **Round-robin pointer `prio` (IW bits)** holds the highest-priority requester index.
  - Search order is prio, prio+1, … mod NREQ.
  - The first valid requester in that order gets req_ready, unless freeze is high.
- **Pointer update:** after a grant to i, prio becomes (i+1) mod NREQ. With no grant, prio holds.
- **Granting never depends on bank state.** A transfer is accepted every cycle that any req_valid is high and freeze is low.
- **Output stage on a transfer by requester i:**
  - reg_d ← req_data[i] and grant_id ← i.
  - grant_vld ← 1.
  - reg_en ← one-hot decode of req_addr[i].
- **Output stage with no transfer:** reg_en ← 0 and grant_vld ← 0. reg_d and grant_id hold their values.
- **Out-of-range address** (req_addr[i] ≥ NREG):
  - The request is still accepted (ready asserted) and the pointer still advances.
  - reg_en ← 0 and grant_vld ← 1.
  - err_addr sets and stays set until reset.
- **Requester obligation:** hold valid, addr and data stable until ready. The block does not buffer unaccepted requests.
- **Two requesters targeting the same address:** they are served in successive cycles in round-robin order. The later write wins in the bank.

## Timing
- **Latency:** with a transfer in cycle N, reg_en/reg_d/grant_id/grant_vld are valid in cycle N+1. The bank captures at the posedge ending cycle N+1, so there are 2 edges from handshake to register update.
- **Throughput:** one write per cycle, sustained.
- **Fairness:** with all NREQ valid continuously, each requester is granted exactly once every NREQ cycles.
- **freeze:**
  - req_ready = 0 in the same cycle.
  - reg_en = 0 and grant_vld = 0 from the next cycle.
  - prio holds.
  - A write already registered before freeze rose still completes.
- **Reset values:** reg_en = 0, reg_d = 0, grant_id = 0, grant_vld = 0, err_addr = 0, prio = 0.
- **Reset during a write:** a write registered in the cycle reset is sampled is dropped, because reg_en is 0 after the reset edge. req_ready is 0 while reset is high.

## Configuration
- **`REGBANK_ARB_FIXED_PRI_EN` defined:** fixed priority, with requester 0 highest and NREQ-1 lowest. prio is removed and the search always starts at 0.
- **Undefined (default):** round-robin as described above.

## Structure
- **Package `regbank_pkg`:**
  - Default NREQ/NREG/DW constants.
  - Helper functions for AW and IW.
  - Typedefs `reg_addr_t` (AW) and `reg_data_t` (DW).
- **Sub-module `rr_pick`:** combinational masked-priority picker.
  - Inputs: req vector, prio.
  - Outputs: one-hot grant, grant index, any.
  - The FIXED_PRI build ties prio to 0.
- **Top level:** pointer register, output registers, address decode, and sticky error.

## Test plan
- **Single request, valid in-range address.** Reset; req_valid=0001, addr0=3, data0=8'hA5 → req_ready=0001 that cycle. Next cycle reg_en=8'h08, reg_d=A5, grant_id=0, grant_vld=1. Following cycle reg_en=0.
- **Round-robin fairness.** All four valid for 8 cycles → grant_id sequence 0,1,2,3,0,1,2,3 (default build). The FIXED_PRI build gives 0 every cycle.
- **Pointer wrap-around.** Grant requester 2, then assert valid on 1 and 3 → 3 is granted first, then 1.
- **freeze during traffic.** Raise freeze during traffic → req_ready=0 immediately; reg_en=0 from the next cycle; prio unchanged on release.
- **Out-of-range address.** NREG=6, addr=7 → ready=1, reg_en=0, grant_vld=1, err_addr=1 and held until reset.
- **Reset during a write.** Assert reset in the cycle after a handshake → reg_en=0 after the edge, all outputs at reset values, prio=0.

Source files
------------

// File: rtl/regbank_wr_arb_pkg.sv
// ----------------------------------------------------------------------------
// regbank_pkg
// Shared constants, width helpers and typedefs for the register-bank write
// arbiter (regbank_wr_arb) and its interface.
//   NREQ_DEF / NREG_DEF / DW_DEF : default requester count, register count,
//                                  data width
//   reg_aw() / reg_iw()          : derived address / requester-index widths
//   reg_addr_t / reg_data_t      : address and data types at default widths
// ----------------------------------------------------------------------------
package regbank_pkg;

    localparam int NREQ_DEF = 4;
    localparam int NREG_DEF = 8;
    localparam int DW_DEF   = 8;

    // Address width for a bank of n registers (at least 1 bit)
    function automatic int reg_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Requester-index width for n requesters (at least 1 bit)
    function automatic int reg_iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int AW_DEF = reg_aw(NREG_DEF);
    localparam int IW_DEF = reg_iw(NREQ_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;
    typedef logic [DW_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regbank_wr_arb_if.sv
// ----------------------------------------------------------------------------
// regbank_wr_arb_if
// Request bus from the write requesters plus the registered write port into
// the register bank.
//   freeze, req_valid, req_addr, req_data : requester side -> arbiter
//   req_ready                             : arbiter -> requesters (one-hot)
//   reg_en, reg_d                         : arbiter -> bank (registered)
//   grant_id, grant_vld, err_addr         : arbiter status (registered)
// Modports: master = requester/bank side, slave = arbiter.
// ----------------------------------------------------------------------------
interface regbank_wr_arb_if
    import regbank_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF
);
    localparam int AW = reg_aw(NREG);
    localparam int IW = reg_iw(NREQ);

    logic                 freeze;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREG-1:0]      reg_en;
    logic [DW-1:0]        reg_d;
    logic [IW-1:0]        grant_id;
    logic                 grant_vld;
    logic                 err_addr;

    modport master (
        output freeze, req_valid, req_addr, req_data,
        input  req_ready, reg_en, reg_d, grant_id, grant_vld, err_addr
    );

    modport slave (
        input  freeze, req_valid, req_addr, req_data,
        output req_ready, reg_en, reg_d, grant_id, grant_vld, err_addr
    );

endinterface

// File: rtl/regbank_wr_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational masked-priority picker. Requests at or above i_prio are
// searched first (lowest index wins); if none exist the unmasked vector is
// searched from index 0, which realises the circular order prio, prio+1, ...
//   i_req  : request vector
//   i_prio : index with highest priority
//   o_gnt  : one-hot grant
//   o_idx  : index of the granted request
//   o_any  : at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_prio,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [NREQ-1:0] w_hi;
    logic [NREQ-1:0] w_masked;
    logic [NREQ-1:0] w_use;

    // Mask of indices at or above the priority pointer
    always_comb begin
        w_hi = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (j >= int'(i_prio)) begin
                w_hi[j] = 1'b1;
            end else begin
                w_hi[j] = 1'b0;
            end
        end
    end

    assign w_masked = i_req & w_hi;
    assign w_use    = (|w_masked) ? w_masked : i_req;
    assign o_any    = |i_req;

    // Lowest set bit of the selected vector; scanning downward lets the
    // lowest index overwrite any higher one
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_use[j]) begin
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end else begin
                o_gnt = o_gnt;
            end
        end
    end

endmodule

// File: rtl/regbank_wr_arb.sv
// ----------------------------------------------------------------------------
// regbank_wr_arb
// Write-port arbiter/sequencer for the register bank. Grants one requester per
// cycle (combinational one-hot req_ready), then presents the accepted write
// one cycle later as a registered one-hot reg_en plus reg_d. Out-of-range
// addresses are still accepted but produce no enable and set sticky err_addr.
//   clk   : clock, posedge
//   reset : synchronous, active-high
//   bus   : regbank_wr_arb_if.slave (request handshake and bank write port)
// Build option: REGBANK_ARB_FIXED_PRI_EN selects fixed priority (requester 0
// highest) and removes the round-robin pointer; default is round-robin.
// ----------------------------------------------------------------------------
module regbank_wr_arb
    import regbank_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    regbank_wr_arb_if.slave    bus
);

    localparam int AW = reg_aw(NREG);
    localparam int IW = reg_iw(NREQ);

    logic [NREQ-1:0] w_req_eff;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic [IW-1:0]   w_prio;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic [NREG-1:0] w_en_dec;
    logic            w_oob;

    logic [NREG-1:0] r_reg_en;
    logic [DW-1:0]   r_reg_d;
    logic [IW-1:0]   r_grant_id;
    logic            r_grant_vld;
    logic            r_err_addr;

    // No grant may be issued while frozen or held in reset
    assign w_req_eff = (bus.freeze || reset) ? '0 : bus.req_valid;

`ifdef REGBANK_ARB_FIXED_PRI_EN
    assign w_prio = '0;
`else
    logic [IW-1:0] r_prio;

    // Round-robin pointer: one past the last granted requester
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= '0;
        end else if (w_any) begin
            r_prio <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign w_prio = r_prio;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req  (w_req_eff),
        .i_prio (w_prio),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign bus.req_ready = w_gnt;

    // One-hot mux of the granted requester's address and data
    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_addr = bus.req_addr[i*AW +: AW];
                w_data = bus.req_data[i*DW +: DW];
            end else begin
                w_addr = w_addr;
                w_data = w_data;
            end
        end
    end

    // Address decode; NREG need not be a power of two, so codes >= NREG
    // decode to no enable and flag an error instead
    always_comb begin
        w_en_dec = '0;
        for (int r = 0; r < NREG; r++) begin
            if (int'(w_addr) == r) begin
                w_en_dec[r] = 1'b1;
            end else begin
                w_en_dec[r] = 1'b0;
            end
        end
        if (int'(w_addr) >= NREG) begin
            w_oob = 1'b1;
        end else begin
            w_oob = 1'b0;
        end
    end

    // Output stage: present the accepted write for exactly one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_en    <= '0;
            r_reg_d     <= '0;
            r_grant_id  <= '0;
            r_grant_vld <= 1'b0;
            r_err_addr  <= 1'b0;
        end else if (w_any) begin
            r_reg_en    <= w_en_dec;
            r_reg_d     <= w_data;
            r_grant_id  <= w_idx;
            r_grant_vld <= 1'b1;
            r_err_addr  <= r_err_addr | w_oob;
        end else begin
            r_reg_en    <= '0;
            r_grant_vld <= 1'b0;
        end
    end

    assign bus.reg_en    = r_reg_en;
    assign bus.reg_d     = r_reg_d;
    assign bus.grant_id  = r_grant_id;
    assign bus.grant_vld = r_grant_vld;
    assign bus.err_addr  = r_err_addr;

endmodule
